cache_controller: RTL and testbench

Sequencing controller that sits between a single CPU requester, the set-associative `Cache` datapath and backing memory. It turns CPU read and write requests into cache lookups. On a read miss it fetches the word from memory and loads it into the cache. Every write goes through to memory. It also keeps saturating hit and miss statistics.

---
 rtl/cache_controller.sv | 181 ++++++++++++++++++
 tb/tb_cache_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// cache_controller: sequences CPU read/write requests through a set-associative
// cache and a backing memory.
// Reads that miss fetch the word from memory and load it into the cache.
// All writes go through to memory.
// Hit and miss counters are kept and saturate at all-ones.
//
// Build option WRITE_ALLOCATE_EN:
//   - defined: a write miss is followed by a FILL that loads the write data
//     into the cache.
//   - undefined (default): a write miss leaves the cache unchanged.
module cache_controller #(
    parameter int TAGLENGTH   = 8,
    parameter int INDEXLENGTH = 6,
    parameter int DATALENGTH  = 32,
    parameter int CNTLENGTH   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cpu_req,
    input  logic                             cpu_we,
    input  logic [TAGLENGTH+INDEXLENGTH-1:0] cpu_addr,
    input  logic [DATALENGTH-1:0]            cpu_wdata,
    output logic                             cpu_ready,
    output logic                             cpu_done,
    output logic [DATALENGTH-1:0]            cpu_rdata,
    output logic [TAGLENGTH-1:0]             cache_tag,
    output logic [INDEXLENGTH-1:0]           cache_index,
    output logic                             cache_re,
    output logic                             cache_we,
    output logic                             cache_loade,
    output logic [DATALENGTH-1:0]            cache_datain,
    input  logic                             cache_hit,
    input  logic [DATALENGTH-1:0]            cache_dataout,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [TAGLENGTH+INDEXLENGTH-1:0] mem_addr,
    output logic [DATALENGTH-1:0]            mem_wdata,
    input  logic                             mem_ack,
    input  logic [DATALENGTH-1:0]            mem_rdata,
    output logic [CNTLENGTH-1:0]             hit_count,
    output logic [CNTLENGTH-1:0]             miss_count
);

    localparam int ADDRLENGTH = TAGLENGTH + INDEXLENGTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_MEM_RD,
        S_MEM_WR,
        S_FILL,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRLENGTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATALENGTH-1:0]   wdata_q, wdata_d;
    logic [DATALENGTH-1:0]   rdata_q, rdata_d;
    logic                    done_q, done_d;
    logic [CNTLENGTH-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNTLENGTH-1:0]    miss_cnt_q, miss_cnt_d;
`ifdef WRITE_ALLOCATE_EN
    logic                    hit_q, hit_d;
`endif

    // State and datapath registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`ifdef WRITE_ALLOCATE_EN
            hit_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
`ifdef WRITE_ALLOCATE_EN
            hit_q      <= hit_d;
`endif
        end
    end

    // Next-state selection for the request sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cpu_req) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                if (we_q)           state_d = S_MEM_WR;
                else if (cache_hit) state_d = S_RESP;
                else                state_d = S_MEM_RD;
            end
            S_MEM_RD: if (mem_ack) state_d = S_FILL;
            S_MEM_WR: begin
                if (mem_ack) begin
`ifdef WRITE_ALLOCATE_EN
                    state_d = hit_q ? S_RESP : S_FILL;
`else
                    state_d = S_RESP;
`endif
                end
            end
            S_FILL:   state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request latch, read-data capture, done pulse and saturating statistics
    always_comb begin
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        done_d     = (state_d == S_RESP);
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
`ifdef WRITE_ALLOCATE_EN
        hit_d      = hit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                end
            end
            S_CHECK: begin
`ifdef WRITE_ALLOCATE_EN
                hit_d = cache_hit;
`endif
                if (cache_hit) begin
                    if (!we_q) rdata_d = cache_dataout;
                    if (hit_cnt_q != {CNTLENGTH{1'b1}})
                        hit_cnt_d = hit_cnt_q + CNTLENGTH'(1);
                end else begin
                    if (miss_cnt_q != {CNTLENGTH{1'b1}})
                        miss_cnt_d = miss_cnt_q + CNTLENGTH'(1);
                end
            end
            S_MEM_RD: if (mem_ack) rdata_d = mem_rdata;
            default: ;
        endcase
    end

    // Strobes and handshakes decoded from the current state
    always_comb begin
        cpu_ready    = (state_q == S_IDLE);
        cache_re     = (state_q == S_LOOKUP) && !we_q;
        cache_we     = (state_q == S_LOOKUP) && we_q;
        cache_loade  = (state_q == S_FILL);
        cache_datain = ((state_q == S_FILL) && !we_q) ? rdata_q : wdata_q;
        mem_req      = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        mem_we       = (state_q == S_MEM_WR);
        cpu_done     = done_q;
        cpu_rdata    = rdata_q;
        cache_tag    = addr_q[ADDRLENGTH-1:INDEXLENGTH];
        cache_index  = addr_q[INDEXLENGTH-1:0];
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
        hit_count    = hit_cnt_q;
        miss_count   = miss_cnt_q;
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: table-driven bench for cache_controller with behavioural
// cache and memory models; a second instance with 4-bit counters checks saturation.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready, cpu_done;
    logic [31:0] cpu_rdata;
    logic [7:0]  cache_tag;
    logic [5:0]  cache_index;
    logic        cache_re, cache_we, cache_loade;
    logic [31:0] cache_datain;
    logic        cache_hit;
    logic [31:0] cache_dataout;
    logic        mem_req, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] hit_count, miss_count;

    logic        s_cpu_ready, s_cpu_done;
    logic [31:0] s_cpu_rdata;
    logic [7:0]  s_cache_tag;
    logic [5:0]  s_cache_index;
    logic        s_cache_re, s_cache_we, s_cache_loade;
    logic [31:0] s_cache_datain;
    logic        s_mem_req, s_mem_we;
    logic [13:0] s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [3:0]  s_hit_count, s_miss_count;

    int check_count = 0;
    int pass_count  = 0;
    int ack_delay   = 0;
    int wait_cnt    = 0;

    logic        cache_valid [0:16383];
    logic [31:0] cache_data  [0:16383];
    logic [31:0] mem_model   [0:16383];

    cache_controller dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cache_tag(cache_tag), .cache_index(cache_index),
        .cache_re(cache_re), .cache_we(cache_we), .cache_loade(cache_loade),
        .cache_datain(cache_datain), .cache_hit(cache_hit), .cache_dataout(cache_dataout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_controller #(.CNTLENGTH(4)) dut_small (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(s_cpu_ready), .cpu_done(s_cpu_done), .cpu_rdata(s_cpu_rdata),
        .cache_tag(s_cache_tag), .cache_index(s_cache_index),
        .cache_re(s_cache_re), .cache_we(s_cache_we), .cache_loade(s_cache_loade),
        .cache_datain(s_cache_datain), .cache_hit(cache_hit), .cache_dataout(cache_dataout),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Behavioural cache keyed by the full address: hit and data registered after a strobe
    always @(posedge clk) begin
        if (cache_re) begin
            cache_hit     <= cache_valid[{cache_tag, cache_index}];
            cache_dataout <= cache_data[{cache_tag, cache_index}];
        end
        if (cache_we) begin
            cache_hit <= cache_valid[{cache_tag, cache_index}];
            if (cache_valid[{cache_tag, cache_index}])
                cache_data[{cache_tag, cache_index}] <= cache_datain;
        end
        if (cache_loade) begin
            cache_valid[{cache_tag, cache_index}] <= 1'b1;
            cache_data[{cache_tag, cache_index}]  <= cache_datain;
        end
    end

    // Behavioural memory: acknowledges after ack_delay cycles of mem_req
    always @(negedge clk) begin
        if (mem_req && !reset) begin
            mem_ack   = (wait_cnt >= ack_delay);
            mem_rdata = mem_model[mem_addr];
            if (mem_ack && mem_we) mem_model[mem_addr] = mem_wdata;
            wait_cnt  = mem_ack ? 0 : wait_cnt + 1;
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] exp_rdata;
        int          exp_latency;
        int          exp_memreq;
        int          exp_loade;
        int          exp_cwe;
        int          exp_hit;
        int          exp_miss;
    } vec_t;

    task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", what, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v, output int lat, output int reqc, output int ldc,
                                 output int wec, output logic [31:0] rd, output logic rdy_after,
                                 output logic done_after);
        ack_delay = v.delay;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        lat = -1; reqc = 0; ldc = 0; wec = 0; rd = '0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (mem_req)     reqc++;
            if (cache_loade) ldc++;
            if (cache_we)    wec++;
            if (cpu_done) begin
                lat = k;
                rd  = cpu_rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        rdy_after  = cpu_ready;
        done_after = cpu_done;
    endtask

    vec_t vecs [0:8];

    initial begin
        int lat, reqc, ldc, wec;
        logic [31:0] rd;
        logic rdy_after, done_after;
        int base_hit, seen, done_seen;

        for (int i = 0; i < 16384; i++) begin
            cache_valid[i] = 1'b0;
            cache_data[i]  = '0;
            mem_model[i]   = '0;
        end
        mem_model[14'h0105] = 32'hDEADBEEF;
        mem_model[14'h3FFF] = 32'hA5A55A5A;

        //          we    addr      wdata         dly rdata         lat req ld cwe hit miss
        vecs[0] = '{1'b0, 14'h0105, 32'h0,        0, 32'hDEADBEEF, 4, 1, 1, 0, 0, 1};
        vecs[1] = '{1'b0, 14'h0105, 32'h0,        0, 32'hDEADBEEF, 2, 0, 0, 0, 1, 1};
        vecs[2] = '{1'b1, 14'h0105, 32'h12345678, 0, 32'hDEADBEEF, 3, 1, 0, 1, 2, 1};
        vecs[3] = '{1'b0, 14'h0105, 32'h0,        0, 32'h12345678, 2, 0, 0, 0, 3, 1};
`ifdef WRITE_ALLOCATE_EN
        vecs[4] = '{1'b1, 14'h0210, 32'hCAFEF00D, 0, 32'h12345678, 4, 1, 1, 1, 3, 2};
        vecs[5] = '{1'b0, 14'h0210, 32'h0,        0, 32'hCAFEF00D, 2, 0, 0, 0, 4, 2};
        vecs[6] = '{1'b0, 14'h3FFF, 32'h0,        3, 32'hA5A55A5A, 7, 4, 1, 0, 4, 3};
        vecs[7] = '{1'b0, 14'h3FFF, 32'h0,        0, 32'hA5A55A5A, 2, 0, 0, 0, 5, 3};
        vecs[8] = '{1'b1, 14'h0000, 32'hFFFFFFFF, 2, 32'hA5A55A5A, 6, 3, 1, 1, 5, 4};
`else
        vecs[4] = '{1'b1, 14'h0210, 32'hCAFEF00D, 0, 32'h12345678, 3, 1, 0, 1, 3, 2};
        vecs[5] = '{1'b0, 14'h0210, 32'h0,        0, 32'hCAFEF00D, 4, 1, 1, 0, 3, 3};
        vecs[6] = '{1'b0, 14'h3FFF, 32'h0,        3, 32'hA5A55A5A, 7, 4, 1, 0, 3, 4};
        vecs[7] = '{1'b0, 14'h3FFF, 32'h0,        0, 32'hA5A55A5A, 2, 0, 0, 0, 4, 4};
        vecs[8] = '{1'b1, 14'h0000, 32'hFFFFFFFF, 2, 32'hA5A55A5A, 5, 3, 0, 1, 4, 5};
`endif

        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(cpu_ready), 32'd1);
        checkOutput("reset_done", 32'(cpu_done), 32'd0);
        checkOutput("reset_rdata", cpu_rdata, 32'h0);
        checkOutput("reset_memreq", 32'({mem_req, mem_we}), 32'd0);
        checkOutput("reset_strobes", 32'({cache_re, cache_we, cache_loade}), 32'd0);
        checkOutput("reset_hits", 32'(hit_count), 32'd0);
        checkOutput("reset_misses", 32'(miss_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], lat, reqc, ldc, wec, rd, rdy_after, done_after);
            $display("[TB] vector %0d addr 0x%04h we %0d", i, vecs[i].addr, vecs[i].we);
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_latency));
            checkOutput($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("v%0d_memreq_cycles", i), 32'(reqc), 32'(vecs[i].exp_memreq));
            checkOutput($sformatf("v%0d_loade_pulses", i), 32'(ldc), 32'(vecs[i].exp_loade));
            checkOutput($sformatf("v%0d_cache_we_pulses", i), 32'(wec), 32'(vecs[i].exp_cwe));
            checkOutput($sformatf("v%0d_hit_count", i), 32'(hit_count), 32'(vecs[i].exp_hit));
            checkOutput($sformatf("v%0d_miss_count", i), 32'(miss_count), 32'(vecs[i].exp_miss));
            checkOutput($sformatf("v%0d_ready_after", i), 32'(rdy_after), 32'd1);
            checkOutput($sformatf("v%0d_done_one_cycle", i), 32'(done_after), 32'd0);
        end

        // Twenty read hits push the 4-bit counters into saturation
        base_hit = vecs[8].exp_hit;
        for (int i = 0; i < 20; i++)
            applyStimulus(vecs[3], lat, reqc, ldc, wec, rd, rdy_after, done_after);
        checkOutput("sat_small_hit_count", 32'(s_hit_count), 32'd15);
        checkOutput("sat_small_miss_count", 32'(s_miss_count), 32'(vecs[8].exp_miss));
        checkOutput("sat_wide_hit_count", 32'(hit_count), 32'(base_hit + 20));
        checkOutput("sat_last_rdata", rd, 32'h12345678);

        // Reset while a memory read is stalled: request is abandoned silently
        ack_delay = 100;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 14'h1111;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (mem_req) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("rst_mid_memreq_seen", 32'(seen), 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_memreq_held", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_memreq_drop", 32'(mem_req), 32'd0);
        checkOutput("rst_mid_ready", 32'(cpu_ready), 32'd1);
        checkOutput("rst_mid_done", 32'(cpu_done), 32'd0);
        checkOutput("rst_mid_hits", 32'(hit_count), 32'd0);
        checkOutput("rst_mid_misses", 32'(miss_count), 32'd0);
        checkOutput("rst_mid_small_hits", 32'(s_hit_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (cpu_done || mem_req || !cpu_ready) done_seen = 1;
        end
        checkOutput("rst_mid_stays_idle", 32'(done_seen), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
